// File: rtl/bank_responder.sv
// ---------------------------------------------------------------------------
// BankResponder: single-account bank back end answering ATM requests.
//
// A request (verify PIN, balance inquiry, withdraw, deposit) is accepted in
// IDLE, processed in EXEC, and answered in RESPOND. The answer stays on the
// outputs until the ATM takes it. Three consecutive wrong PINs (MAX_TRIES)
// lock the account until reset.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req_valid    ATM request present
//   req_ready    responder can accept a request (IDLE only)
//   req_op       00 verify PIN, 01 balance, 10 withdraw, 11 deposit
//   req_pin      PIN for op 00
//   req_amount   unsigned amount for ops 10/11
//   session_end  one-cycle pulse when the card is ejected
//   rsp_valid    response present
//   rsp_ready    ATM accepts the response
//   rsp_status   0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 NOT_AUTH,
//                5 OVERFLOW
//   rsp_balance  balance after the operation
//   locked       account locked
//   audit_count  (only with BANK_AUDIT_EN) saturating count of OK responses
//
// Build option: define BANK_AUDIT_EN to add the audit_count output.
// ---------------------------------------------------------------------------
module bank_responder #(
    parameter logic [31:0] INIT_BALANCE = 32'h000F4240,
    parameter logic [3:0]  PIN_CODE     = 4'b1010,
    parameter int          MAX_TRIES    = 3,
    parameter int          PROC_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [3:0]  req_pin,
    input  logic [31:0] req_amount,
    input  logic        session_end,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_status,
    output logic [31:0] rsp_balance,
    output logic        locked
`ifdef BANK_AUDIT_EN
    ,
    output logic [15:0] audit_count
`endif
);

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_BAD_PIN  = 3'd1;
    localparam logic [2:0] ST_LOCKED   = 3'd2;
    localparam logic [2:0] ST_INSUFF   = 3'd3;
    localparam logic [2:0] ST_NOT_AUTH = 3'd4;
    localparam logic [2:0] ST_OVERFLOW = 3'd5;

    localparam int             FW        = $clog2(MAX_TRIES + 1);
    localparam logic [FW-1:0]  MAX_T     = FW'(MAX_TRIES);
    localparam int             CW        = $clog2(PROC_CYCLES + 2);
    localparam logic [CW-1:0]  EXEC_LAST = CW'(PROC_CYCLES);

    typedef enum logic [1:0] {IDLE, EXEC, RESPOND} state_t;

    state_t         r_state;
    state_t         w_nextState;

    logic           r_outEn;
    logic [1:0]     r_op;
    logic [3:0]     r_pin;
    logic [31:0]    r_amount;
    logic [CW-1:0]  r_execCnt;
    logic [31:0]    r_balance;
    logic [2:0]     r_status;
    logic           r_auth;
    logic [FW-1:0]  r_failCnt;
    logic           r_locked;
    logic           r_sessPending;

    logic           w_accept;
    logic           w_execDone;
    logic           w_rspTaken;
    logic [32:0]    w_sum;
    logic [FW:0]    w_failPlus;
    logic [2:0]     w_resStatus;
    logic [31:0]    w_resBalance;
    logic           w_resAuth;
    logic [FW-1:0]  w_resFail;
    logic           w_resLocked;

    assign w_accept   = req_valid && req_ready;
    assign w_execDone = (r_state == EXEC) && (r_execCnt == EXEC_LAST);
    assign w_rspTaken = (r_state == RESPOND) && rsp_ready;
    assign w_sum      = {1'b0, r_balance} + {1'b0, r_amount};
    assign w_failPlus = {1'b0, r_failCnt} + (FW + 1)'(1);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // FSM next state; EXEC holds until the counter reaches PROC_CYCLES,
    // which puts rsp_valid PROC_CYCLES+1 edges after acceptance
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_nextState = EXEC;
            EXEC:    if (w_execDone) w_nextState = RESPOND;
            RESPOND: if (rsp_ready)  w_nextState = IDLE;
            default:                 w_nextState = IDLE;
        endcase
    end

    // FSM outputs; r_outEn keeps req_ready low until the first edge after reset
    always_comb begin
        req_ready = (r_state == IDLE) && r_outEn;
        rsp_valid = (r_state == RESPOND);
    end

    // Operation result, evaluated from the captured request and account state
    always_comb begin
        w_resStatus  = ST_OK;
        w_resBalance = r_balance;
        w_resAuth    = r_auth;
        w_resFail    = r_failCnt;
        w_resLocked  = r_locked;
        if (r_locked) begin
            w_resStatus = ST_LOCKED;
        end else begin
            case (r_op)
                2'b00: begin
                    if (r_pin == PIN_CODE) begin
                        w_resAuth = 1'b1;
                        w_resFail = '0;
                    end else begin
                        w_resStatus = ST_BAD_PIN;
                        if (w_failPlus >= {1'b0, MAX_T}) begin
                            w_resFail   = MAX_T;
                            w_resLocked = 1'b1;
                            w_resAuth   = 1'b0;
                        end else begin
                            w_resFail = w_failPlus[FW-1:0];
                        end
                    end
                end
                2'b01: begin
                    if (!r_auth) w_resStatus = ST_NOT_AUTH;
                end
                2'b10: begin
                    if (!r_auth)                    w_resStatus = ST_NOT_AUTH;
                    else if (r_amount > r_balance)  w_resStatus = ST_INSUFF;
                    else                            w_resBalance = r_balance - r_amount;
                end
                default: begin
                    if (!r_auth)        w_resStatus = ST_NOT_AUTH;
                    else if (w_sum[32]) w_resStatus = ST_OVERFLOW;
                    else                w_resBalance = w_sum[31:0];
                end
            endcase
        end
    end

    // Request capture, processing counter and account state. Account changes
    // commit only on the EXEC->RESPOND edge, so a reset earlier drops them.
    // session_end in IDLE clears authentication at once (including on the
    // acceptance edge); otherwise it waits until the response is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outEn       <= 1'b0;
            r_op          <= 2'b00;
            r_pin         <= 4'b0000;
            r_amount      <= '0;
            r_execCnt     <= '0;
            r_balance     <= INIT_BALANCE;
            r_status      <= ST_OK;
            r_auth        <= 1'b0;
            r_failCnt     <= '0;
            r_locked      <= 1'b0;
            r_sessPending <= 1'b0;
        end else begin
            r_outEn <= 1'b1;
            if (w_accept) begin
                r_op      <= req_op;
                r_pin     <= req_pin;
                r_amount  <= req_amount;
                r_execCnt <= '0;
            end
            if (r_state == EXEC) begin
                if (w_execDone) begin
                    r_status  <= w_resStatus;
                    r_balance <= w_resBalance;
                    r_auth    <= w_resAuth;
                    r_failCnt <= w_resFail;
                    r_locked  <= w_resLocked;
                end else begin
                    r_execCnt <= r_execCnt + CW'(1);
                end
            end
            if (r_state == IDLE && session_end) begin
                r_auth <= 1'b0;
            end
            if (w_rspTaken) begin
                if (r_sessPending || session_end) r_auth <= 1'b0;
                r_sessPending <= 1'b0;
            end else if (r_state != IDLE && session_end) begin
                r_sessPending <= 1'b1;
            end
        end
    end

    assign rsp_status  = r_status;
    assign rsp_balance = r_balance;
    assign locked      = r_locked;

`ifdef BANK_AUDIT_EN
    logic [15:0] r_auditCnt;

    // Count responses taken by the ATM with status OK, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_auditCnt <= '0;
        end else if (w_rspTaken && r_status == ST_OK && r_auditCnt != 16'hFFFF) begin
            r_auditCnt <= r_auditCnt + 16'd1;
        end
    end

    assign audit_count = r_auditCnt;
`endif

endmodule

// File: tb/tb_bank_responder.sv
// ---------------------------------------------------------------------------
// tb_bank_responder: directed vectors for BankResponder with hand-computed
// expected status/balance values, default parameters.
// ---------------------------------------------------------------------------
module tb_bank_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_pin;
    logic [31:0] req_amount;
    logic        session_end;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_balance;
    logic        locked;
`ifdef BANK_AUDIT_EN
    logic [15:0] audit_count;
`endif

    int numVectors;
    int numMiscompares;

    bank_responder dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_pin     (req_pin),
        .req_amount  (req_amount),
        .session_end (session_end),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance),
        .locked      (locked)
`ifdef BANK_AUDIT_EN
        ,
        .audit_count (audit_count)
`endif
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector, reports miscompares
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numVectors++;
        if (observed !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full request/response transaction. sessAt selects the edge (0 is
    // the acceptance edge) on which session_end pulses, -1 for none. The
    // response is held for 'hold' cycles before rsp_ready is raised.
    task automatic applyStimulus(input string tag, input logic [1:0] op,
                                 input logic [3:0] pin, input logic [31:0] amt,
                                 input int sessAt, input int hold,
                                 input logic [2:0] expStatus,
                                 input logic [31:0] expBalance);
        int n;
        int lat;
        @(negedge clk);
        req_op      = op;
        req_pin     = pin;
        req_amount  = amt;
        req_valid   = 1'b1;
        session_end = (sessAt == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput({tag, ".acceptTimeout"}, 32'(req_ready), 32'd1);
            req_valid   = 1'b0;
            session_end = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 30) begin
            session_end = (lat + 1 == sessAt);
            @(posedge clk);
            #1;
            lat++;
        end
        session_end = 1'b0;
        if (!rsp_valid) begin
            checkOutput({tag, ".rspTimeout"}, 32'(rsp_valid), 32'd1);
            return;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'd3);
        checkOutput({tag, ".status"}, 32'(rsp_status), 32'(expStatus));
        checkOutput({tag, ".balance"}, rsp_balance, expBalance);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, ".holdValid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, ".holdReady"}, 32'(req_ready), 32'd0);
            checkOutput({tag, ".holdStatus"}, 32'(rsp_status), 32'(expStatus));
            checkOutput({tag, ".holdBalance"}, rsp_balance, expBalance);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        numVectors     = 0;
        numMiscompares = 0;
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_pin     = 4'b0000;
        req_amount  = 32'd0;
        session_end = 1'b0;
        rsp_ready   = 1'b0;

        // Outputs while reset is held
        repeat (3) @(negedge clk);
        checkOutput("rst.reqReady", 32'(req_ready), 32'd0);
        checkOutput("rst.rspValid", 32'(rsp_valid), 32'd0);
        checkOutput("rst.rspStatus", 32'(rsp_status), 32'd0);
        checkOutput("rst.rspBalance", rsp_balance, 32'd1000000);
        checkOutput("rst.locked", 32'(locked), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rst.readyBeforeEdge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst.readyAfterEdge", 32'(req_ready), 32'd1);

        // Authenticate and query
        applyStimulus("pinOk",    2'b00, 4'b1010, 32'd0, -1, 0, 3'd0, 32'd1000000);
        applyStimulus("balance",  2'b01, 4'b0000, 32'd0, -1, 0, 3'd0, 32'd1000000);

        // Withdraw down to zero, then one too many
        applyStimulus("wdAll",    2'b10, 4'b0000, 32'd1000000, -1, 0, 3'd0, 32'd0);
        applyStimulus("wdOne",    2'b10, 4'b0000, 32'd1, -1, 0, 3'd3, 32'd0);

        // Zero amounts
        applyStimulus("dep0",     2'b11, 4'b0000, 32'd0, -1, 0, 3'd0, 32'd0);
        applyStimulus("wd0",      2'b10, 4'b0000, 32'd0, -1, 0, 3'd0, 32'd0);

        // Deposit up to the 32-bit ceiling
        applyStimulus("depBig",   2'b11, 4'b0000, 32'hFFFFFFF0, -1, 0, 3'd0, 32'hFFFFFFF0);
        applyStimulus("depOvf",   2'b11, 4'b0000, 32'h20, -1, 0, 3'd5, 32'hFFFFFFF0);
        applyStimulus("depMax",   2'b11, 4'b0000, 32'hF, -1, 0, 3'd0, 32'hFFFFFFFF);

        // Held response with session_end during EXEC; deauth takes effect after
        applyStimulus("holdSess", 2'b01, 4'b0000, 32'd0, 1, 5, 3'd0, 32'hFFFFFFFF);
        applyStimulus("afterSess",2'b01, 4'b0000, 32'd0, -1, 0, 3'd4, 32'hFFFFFFFF);
        applyStimulus("wdNoAuth", 2'b10, 4'b0000, 32'd5, -1, 0, 3'd4, 32'hFFFFFFFF);

        // session_end on the acceptance edge itself
        applyStimulus("reAuth",   2'b00, 4'b1010, 32'd0, -1, 0, 3'd0, 32'hFFFFFFFF);
        applyStimulus("sessSame", 2'b01, 4'b0000, 32'd0, 0, 0, 3'd4, 32'hFFFFFFFF);

        // Reset in the middle of EXEC of a withdraw
        applyStimulus("auth3",    2'b00, 4'b1010, 32'd0, -1, 0, 3'd0, 32'hFFFFFFFF);
        @(negedge clk);
        req_op     = 2'b10;
        req_amount = 32'd500;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        checkOutput("midRst.rspValid", 32'(rsp_valid), 32'd0);
        checkOutput("midRst.balance", rsp_balance, 32'd1000000);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("midRst.noRsp", 32'(rsp_valid), 32'd0);
        checkOutput("midRst.ready", 32'(req_ready), 32'd1);
        applyStimulus("midRstQ",  2'b01, 4'b0000, 32'd0, -1, 0, 3'd4, 32'd1000000);

        // Lockout after three wrong PINs
        applyStimulus("bad1",     2'b00, 4'b0000, 32'd0, -1, 0, 3'd1, 32'd1000000);
        applyStimulus("bad2",     2'b00, 4'b0000, 32'd0, -1, 0, 3'd1, 32'd1000000);
        checkOutput("bad2.locked", 32'(locked), 32'd0);
        applyStimulus("bad3",     2'b00, 4'b0000, 32'd0, -1, 0, 3'd1, 32'd1000000);
        checkOutput("bad3.locked", 32'(locked), 32'd1);
        applyStimulus("lockPin",  2'b00, 4'b1010, 32'd0, -1, 0, 3'd2, 32'd1000000);
        applyStimulus("lockQ",    2'b01, 4'b0000, 32'd0, -1, 0, 3'd2, 32'd1000000);
        checkOutput("lockQ.locked", 32'(locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule

// File: doc/bank_responder.md
BANK_RESPONDER -- requirements
Module: bank_responder

Interface
REQ-001 SHALL have parameter INIT_BALANCE, default 32'h000F4240, account balance loaded at reset.
REQ-002 SHALL have parameter PIN_CODE, default 4'b1010, the correct account PIN.
REQ-003 SHALL have parameter MAX_TRIES, default 3, the consecutive wrong-PIN count that locks the account.
REQ-004 SHALL have parameter PROC_CYCLES, default 2, the processing cycles between request acceptance and response.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  ATM request present.
REQ-008 req_ready  out  1  responder can accept a request.
REQ-009 req_op  in  2  00 verify PIN, 01 balance inquiry, 10 withdraw, 11 deposit.
REQ-010 req_pin  in  4  PIN, used only for op 00.
REQ-011 req_amount  in  32  unsigned amount, used only for ops 10/11.
REQ-012 session_end  in  1  one-cycle pulse, card ejected; clears authentication.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  ATM accepts response.
REQ-015 rsp_status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 NOT_AUTH, 5 OVERFLOW.
REQ-016 rsp_balance  out  32  balance after the operation.
REQ-017 locked  out  1  account locked.

Function
REQ-018 SHALL implement FSM IDLE -> EXEC -> RESPOND -> IDLE; req_ready SHALL be 1 only in IDLE.
REQ-019 Request SHALL be accepted on a rising edge with req_valid&req_ready; op, pin, amount SHALL be captured then.
REQ-020 EXEC SHALL last exactly PROC_CYCLES cycles; rsp_valid SHALL rise PROC_CYCLES+1 edges after the acceptance edge.
REQ-021 In RESPOND, rsp_valid, rsp_status, rsp_balance SHALL stay stable until an edge with rsp_ready=1, then return to IDLE; rsp_valid and req_ready SHALL never both be 1.
REQ-022 When locked, every op SHALL return LOCKED with no state change.
REQ-023 Op 00: pin==PIN_CODE -> OK, authenticated, fail count cleared; else BAD_PIN, fail count +1; reaching MAX_TRIES SHALL set locked and clear authentication.
REQ-024 Ops 01/10/11 while unauthenticated SHALL return NOT_AUTH, balance unchanged.
REQ-025 Withdraw: amount<=balance -> OK, balance-=amount (equal leaves 0); amount>balance -> INSUFFICIENT, unchanged.
REQ-026 Deposit: 33-bit sum; sum>32'hFFFFFFFF -> OVERFLOW, unchanged; else OK, balance updated.
REQ-027 Amount 0 SHALL return OK with balance unchanged.
REQ-028 rsp_balance SHALL always carry the balance after the operation.
REQ-029 session_end outside IDLE SHALL be held pending and clear authentication on return to IDLE, after the current response.
REQ-030 session_end on the same edge as acceptance SHALL apply first; the accepted request is evaluated unauthenticated.
REQ-031 Fail count SHALL saturate at MAX_TRIES; locked cleared only by reset.

Reset
REQ-032 Reset SHALL force IDLE, balance=INIT_BALANCE, fail count 0, unauthenticated, locked 0, session_end pending 0.
REQ-033 During reset outputs SHALL be req_ready 0, rsp_valid 0, rsp_status 0, rsp_balance INIT_BALANCE; req_ready rises the first edge after deassertion.
REQ-034 Reset mid-EXEC or mid-RESPOND SHALL drop the pending response and discard any balance change.

Configuration
REQ-035 With BANK_AUDIT_EN defined, SHALL add output audit_count (16 bits), +1 per completed response with status OK, saturating at 16'hFFFF, reset 0.
REQ-036 Without BANK_AUDIT_EN, audit_count port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-037 Reset, op 00 pin 4'b1010, op 01 -> both OK, rsp_balance 1000000, rsp_valid PROC_CYCLES+1 edges after accept.
REQ-038 Authenticated, withdraw 1000000 then withdraw 1 -> OK balance 0, then INSUFFICIENT balance 0.
REQ-039 Three op 00 with pin 4'b0000, then pin 4'b1010 -> BAD_PIN x3, locked=1, then LOCKED.
REQ-040 Balance 32'hFFFFFFF0, deposit 32'h20 -> OVERFLOW, balance unchanged; deposit 32'hF -> OK, 32'hFFFFFFFF.
REQ-041 Hold rsp_ready 0 for 5 cycles -> response stable, req_ready 0; session_end during EXEC -> next op 01 returns NOT_AUTH.
REQ-042 Reset pulse during EXEC of withdraw 500 -> rsp_valid 0, balance 1000000, unauthenticated.
